// File: rtl/perceptron_result_unloader_if.sv
// Handshake bundle between the result register bank, the unloader and the result consumer.
// The slave modport is the unloader's view; the master modport is the surrounding logic.
interface perceptron_result_unloader_if #(
    parameter int DWIDTH = 32,
    parameter int NUM    = 4,
    parameter int IDXW   = $clog2(NUM)
);
    logic                  cap_valid;
    logic [NUM*DWIDTH-1:0] cap_data;
    logic                  cap_ready;
    logic [DWIDTH-1:0]     out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDXW-1:0]       out_index;
    logic                  out_last;
    logic                  busy;
    logic                  drop_err;

    modport slave (
        input  cap_valid, cap_data, out_ready,
        output cap_ready, out_data, out_valid, out_index, out_last, busy, drop_err
    );

    modport master (
        output cap_valid, cap_data, out_ready,
        input  cap_ready, out_data, out_valid, out_index, out_last, busy, drop_err
    );
endinterface

// File: rtl/perceptron_result_unloader.sv
// Snapshots NUM signed neuron results and streams them out one slot per handshake.
// Latency 1 cycle capture-to-first-slot; captures arriving while streaming are refused and flagged.
module perceptron_result_unloader #(
    parameter int DWIDTH = 32,
    parameter int NUM    = 4,
    parameter int IDXW   = $clog2(NUM)
) (
    input  logic                        clk,
    input  logic                        reset,
    perceptron_result_unloader_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_drop;
    logic [DWIDTH-1:0] r_snap [NUM];

    logic w_stream;
    logic w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_drop  <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cap_valid) begin
                        for (int i = 0; i < NUM; i++) begin
                            r_snap[i] <= bus.cap_data[i*DWIDTH +: DWIDTH];
                        end
                        r_idx   <= '0;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    // Includes a request on the final-handshake edge: the bank must retry next cycle.
                    if (bus.cap_valid) begin
                        r_drop <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stream = (r_state == STREAM);
    assign w_last   = (r_idx == LAST_IDX);

    assign bus.cap_ready = ~w_stream;
    assign bus.out_valid = w_stream;
    assign bus.busy      = w_stream;
    assign bus.drop_err  = r_drop;
    assign bus.out_data  = w_stream ? r_snap[r_idx] : '0;
    assign bus.out_index = w_stream ? r_idx : '0;
    assign bus.out_last  = w_stream & w_last;
endmodule

// File: doc/perceptron_result_unloader.md
PERCEPTRON_RESULT_UNLOADER -- requirements
Module: perceptron_result_unloader

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning width of one signed neuron result.
REQ-002 SHALL have parameter NUM, default 4, meaning number of neuron results per capture; legal range 2..16.
REQ-003 SHALL have parameter IDXW, default $clog2(NUM), meaning width of the slot index.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cap_valid  input  1  capture request from the result register bank.
REQ-007 SHALL have port cap_data  input  NUM*DWIDTH  packed signed results; slot i = cap_data[i*DWIDTH +: DWIDTH].
REQ-008 SHALL have port cap_ready  output  1  unloader can accept a capture.
REQ-009 SHALL have port out_data  output  DWIDTH  signed result of the current slot.
REQ-010 SHALL have port out_valid  output  1  out_data/out_index/out_last are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the current slot.
REQ-012 SHALL have port out_index  output  IDXW  slot number of out_data.
REQ-013 SHALL have port out_last  output  1  current slot is NUM-1.
REQ-014 SHALL have port busy  output  1  a snapshot is being streamed.
REQ-015 SHALL have port drop_err  output  1  sticky flag: a capture request was refused.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, STREAM.
REQ-017 SHALL drive cap_ready=1 exactly in IDLE and 0 in STREAM; cap_ready SHALL be a function of registered state only.
REQ-018 SHALL, on a rising edge with cap_valid=1 in IDLE, copy all NUM slots of cap_data into an internal snapshot buffer, set index to 0, and enter STREAM.
REQ-019 SHALL assert out_valid and busy in the first cycle after the capture edge (latency 1 cycle) and keep them high throughout STREAM; both 0 in IDLE.
REQ-020 SHALL drive out_data = snapshot[index], out_index = index, out_last = (index == NUM-1) in STREAM; out_data, out_index, out_last SHALL be 0 in IDLE.
REQ-021 SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0 (any number of stall cycles).
REQ-022 SHALL, on a handshake edge (out_valid=1, out_ready=1) with index < NUM-1, increment index by 1 and remain in STREAM.
REQ-023 SHALL, on a handshake edge with index == NUM-1, return to IDLE; index SHALL NOT wrap to 0 inside STREAM.
REQ-024 SHALL be insensitive to cap_data changes after the capture edge; streamed values come only from the snapshot.
REQ-025 SHALL, on any rising edge with cap_valid=1 in STREAM, ignore the request (snapshot, index, state unchanged) and set drop_err=1.
REQ-026 SHALL treat a cap_valid=1 on the same edge as the final handshake as refused (REQ-025 applies); the next capture is accepted no earlier than the following edge.
REQ-027 SHALL keep drop_err=1 until reset; no other clear path.
REQ-028 SHALL pass signed values bit-exact; no saturation, rounding or sign manipulation.
REQ-029 SHALL sustain one slot per cycle when out_ready is held 1: a full unload takes NUM cycles in STREAM, capture-to-capture minimum NUM+1 cycles.

Reset
REQ-030 SHALL, on a rising edge with reset=1, enter IDLE, clear index, snapshot buffer and drop_err to 0, regardless of state or other inputs.
REQ-031 SHALL give reset priority over capture and handshake on the same edge; a stream in progress is abandoned with no further out_valid.
REQ-032 SHALL present after reset: cap_ready=1, out_valid=0, busy=0, out_data=0, out_index=0, out_last=0, drop_err=0.

Verification
REQ-033 SHALL cover basic unload: NUM=4, capture slots {5,-3,0x7FFFFFFF,0x80000000}, out_ready=1 -> out_valid cycles 1..4 after capture, out_data 5,-3,0x7FFFFFFF,0x80000000, out_index 0..3, out_last only on index 3, then cap_ready=1.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles on slot 1 -> out_data=-3, out_index=1 held 3 cycles, advances on the first out_ready=1 edge.
REQ-035 SHALL cover capture while busy: cap_valid=1 with new data during STREAM -> streamed values unchanged, drop_err=1 and stays 1 after return to IDLE until reset.
REQ-036 SHALL cover boundary: cap_valid=1 on the last-handshake edge -> refused, drop_err=1; cap_valid=1 on the next edge -> accepted, out_valid one cycle later.
REQ-037 SHALL cover reset mid-stream: reset=1 at slot 2 -> next cycle out_valid=0, cap_ready=1, out_index=0, drop_err=0; a new capture streams from slot 0.
REQ-038 SHALL cover input isolation: cap_data changed every cycle after capture -> all streamed values equal captured snapshot.
